// File: rtl/dm_mem_responder_upstream_pkg.sv
// Shared cache<->memory interface types for the upstream direct-mapped cache.
// Also holds the responder FSM state type and its default latency.
package cache_def;

   typedef logic [127:0] cache_data_type;

   typedef struct packed {
      logic [31:0]    addr;
      cache_data_type data;
      logic           rw;
      logic           valid;
   } mem_req_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_data_type;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_resp_state_type;

   localparam int MEM_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/dm_mem_responder_upstream_array.sv
// Line store behind the memory responder: asynchronous read, synchronous write.
// Contents are filled with INIT_LINE at time zero and are never touched by reset.
module dm_mem_array_upstream
   import cache_def::*;
#(
   parameter int             LINES     = 1024,
   parameter cache_data_type INIT_LINE = '0
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(LINES)-1:0] idx,
   input  cache_data_type           wdata,
   output cache_data_type           rdata
);

   cache_data_type mem_q [LINES] = '{default: INIT_LINE};

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/dm_mem_responder_upstream.sv
// Fixed-latency main-memory responder for the upstream direct-mapped cache.
// Optional request statistics are built only when MEM_RESP_STATS_EN is defined.
module dm_mem_responder_upstream
   import cache_def::*;
#(
   parameter int             LINES     = 1024,
   parameter int             LATENCY   = MEM_LATENCY_DEFAULT,
   parameter cache_data_type INIT_LINE = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  mem_req_type        mem_req,
   output mem_data_type       mem_data,
   output logic [31:0]        rd_count,
   output logic [31:0]        wr_count,
   output mem_resp_state_type state
);

   localparam int         IDX_W    = $clog2(LINES);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   mem_resp_state_type state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   cache_data_type     resp_q, resp_d;
   cache_data_type     out_q, out_d;

   logic               accept;
   logic               we;
   logic [IDX_W-1:0]   idx;
   cache_data_type     rdata;
   logic               unused_addr_bits;

   // RESP accepts like IDLE so a write-back can be followed by an allocate read without a bubble.
   assign accept = mem_req.valid && ((state_q == IDLE) || (state_q == RESP));
   assign idx    = mem_req.addr[IDX_W+3:4];
   assign we     = accept && mem_req.rw && !rst;
   assign unused_addr_bits = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

   dm_mem_array_upstream #(
      .LINES     (LINES),
      .INIT_LINE (INIT_LINE)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .idx   (idx),
      .wdata (mem_req.data),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      out_d   = out_q;

      case (state_q)
         BUSY: begin
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: ;
      endcase

      if (accept) begin
         resp_d = mem_req.rw ? mem_req.data : rdata;
         if (LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
         end else begin
            state_d = RESP;
         end
      end

      // The visible data only changes when a response is presented, so it holds while ready is low.
      if (state_d == RESP) begin
         out_d = resp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         resp_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         out_q   <= out_d;
      end
   end

   assign mem_data.data  = out_q;
   assign mem_data.ready = (state_q == RESP);
   assign state          = state_q;

`ifdef MEM_RESP_STATS_EN
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (accept) begin
         if (mem_req.rw) begin
            wr_count_d = wr_count_q + 32'd1;
         end else begin
            rd_count_d = rd_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= 32'd0;
         wr_count_q <= 32'd0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   assign rd_count = 32'h0;
   assign wr_count = 32'h0;
`endif

endmodule
